ctl_xcry_seq: RTL and testbench
===============================

// Module: ctl_xcry_seq
// PURPOSE
//  Parametrised multi-word adder carry sequencer for the CTL board. Generates the AD
//  carry-in for each word of a 1..MAXWORDS-word add, with the XCRY/AR0 and PI-cycle
//  flag-save rules applied to the first word. Chains each word's carry-out into the
//  next word, drives AD long, and latches the CRY0/CRY1 flags from the final word.
//  Sits between CRAM decode and the AD datapath; the datapath paces it with step.
// PARAMETERS
//  MAXWORDS  2  maximum words per operation (>=1)
//  CNTW      2  width of nwords/word_idx; must hold MAXWORDS
// PORTS
//  clk            in   1     system clock
//  reset          in   1     synchronous, active-high reset
//  start          in   1     begin operation (accepted only in IDLE)
//  nwords         in   CNTW  word count for this op; 0 treated as 1, >MAXWORDS clamped
//  cram_ad_carry  in   1     CRAM AD carry field
//  spec_xcry_ar0  in   1     special function: carry-in from AR0
//  ar0            in   1     AR bit 0
//  pc_plus1_inh   in   1     PC+1 inhibit (PI cycle)
//  step           in   1     datapath finished current word this cycle
//  ad_cout        in   1     carry out of current word MSB (valid with step)
//  ad_cin_msb     in   1     carry into current word MSB (valid with step)
//  clr_flags      in   1     clear CRY0/CRY1
//  ad_carry_in    out  1     carry into LSB of current word
//  ad_long        out  1     multi-word op active, current word not last
//  busy           out  1     operation in progress
//  word_idx       out  CNTW  index of current word, 0 = least significant
//  done           out  1     one-cycle pulse: operation complete
//  pi_save_flags  out  1     captured pc_plus1_inh & spec_xcry_ar0 for this op
//  cry0, cry1     out  1     latched carry-out-of / carry-into MSB flags
//  ovf            out  1     cry0 ^ cry1 (combinational from latched flags)
// BEHAVIOUR
//  - All outputs registered except ovf, ad_long; reset drives every output/state to 0.
//  - States: IDLE, RUN. last = clamp(nwords)-1 captured at start.
//  - IDLE & start (edge N): from N+1 busy=1, word_idx=0, RUN,
//      pi_save_flags = pc_plus1_inh & spec_xcry_ar0,
//      ad_carry_in = ~pi_save & ((ar0 & spec_xcry_ar0) ^ cram_ad_carry).
//  - RUN & step & word_idx!=last: word_idx+1, ad_carry_in <= ad_cout.
//  - RUN & step & word_idx==last: cry0<=ad_cout, cry1<=ad_cin_msb unless pi_save_flags
//      (flags hold); done=1 next cycle; busy=0, state IDLE same edge.
//  - RUN & !step: all held; ad_carry_in stable between steps.
//  - ad_long = busy & (word_idx != last).
//  - start while busy ignored; step in IDLE ignored; new start accepted in the done cycle.
//  - clr_flags clears cry0/cry1 in any state; final-word latch on same edge wins.
//  - reset mid-op: abort, no done, flags cleared.
//  - Single-word op with step on first RUN cycle: done 2 cycles after start edge.
// STRUCTURE
//  - Shared ctl package: state enum {IDLE,RUN}; function xcry_cin(ar0,spec,cram,inh).
//  - Flag latch (cry0/cry1/clr/inhibit) is a natural sub-module: ctl_cry_flags.
//  - Remaining sequencing flat in this module.
// TESTING
//  - 1 word, cram_ad_carry=1, spec=0, step w/ ad_cout=1,cin_msb=0 -> cin=1, cry0=1,cry1=0,ovf=1, done.
//  - 2 words, spec=1,ar0=1,cram=0; step1 ad_cout=1 -> word0 cin=1, word1 cin=1, ad_long 1 then 0.
//  - pc_plus1_inh=1,spec=1,ar0=1 -> cin=0, pi_save_flags=1, cry0/cry1 keep prior values at done.
//  - Start while busy, step in IDLE, nwords=0 and nwords=3 (MAXWORDS=2) -> ignored / 1 word / 2 words.
//  - clr_flags with final step same edge -> flags take new values; clr alone -> 0.
//  - Reset asserted mid 2-word op -> busy=0, no done, cry0=cry1=0, next start runs normally.

Source files
------------

// File: rtl/ctl_xcry_seq_pkg.sv
// Shared CTL definitions for the multi-word adder carry sequencer:
// sequencer state encoding and the first-word carry-in rule.
package ctl_xcry_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctl_state_e;

  // First-word AD carry-in: AR0 is folded into the CRAM carry when the XCRY
  // special function is selected, and the whole carry is forced to zero on a
  // PI cycle that saves flags (pc_plus1_inh together with the special function).
  function automatic logic xcry_cin(input logic ar0, input logic spec,
                                    input logic cram, input logic inh);
    return ~(inh & spec) & ((ar0 & spec) ^ cram);
  endfunction

endpackage

// File: rtl/ctl_xcry_seq_cry_flags.sv
// CRY0/CRY1 flag latch. Loads the final word's carry-out / carry-into-MSB
// unless the operation saves flags (inhibit). A load on the same edge as
// clr wins over the clear. ovf is derived combinationally from the latch.
module ctl_cry_flags (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic inhibit,
  input  logic cout,
  input  logic cin_msb,
  output logic cry0,
  output logic cry1,
  output logic ovf
);

  // Flag register: reset, then final-word load, then clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      cry0 <= 1'b0;
      cry1 <= 1'b0;
    end else if (load && !inhibit) begin
      cry0 <= cout;
      cry1 <= cin_msb;
    end else if (clr) begin
      cry0 <= 1'b0;
      cry1 <= 1'b0;
    end
  end

  // Overflow is the disagreement of the two carries around the MSB.
  always_comb begin
    ovf = cry0 ^ cry1;
  end

endmodule

// File: rtl/ctl_xcry_seq.sv
// Multi-word adder carry sequencer. Issues the AD carry-in for each word of a
// 1..MAXWORDS-word add, chains word carries, drives ad_long and latches the
// final carry flags.
//
// Handshake: start is a request that is taken only while the sequencer is
// idle (busy=0); it is ignored while busy. step is a one-cycle strobe from the
// datapath meaning "current word finished"; ad_cout/ad_cin_msb are only
// meaningful in a cycle with step=1, and step is ignored while idle. done is a
// one-cycle completion pulse, during which a new start is already accepted.
module ctl_xcry_seq
  import ctl_xcry_seq_pkg::*;
#(
  parameter int MAXWORDS = 2,
  parameter int CNTW     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CNTW-1:0] nwords,
  input  logic            cram_ad_carry,
  input  logic            spec_xcry_ar0,
  input  logic            ar0,
  input  logic            pc_plus1_inh,
  input  logic            step,
  input  logic            ad_cout,
  input  logic            ad_cin_msb,
  input  logic            clr_flags,
  output logic            ad_carry_in,
  output logic            ad_long,
  output logic            busy,
  output logic [CNTW-1:0] word_idx,
  output logic            done,
  output logic            pi_save_flags,
  output logic            cry0,
  output logic            cry1,
  output logic            ovf
);

  localparam logic [CNTW-1:0] MAX_IDX = CNTW'(MAXWORDS - 1);

  ctl_state_e      state_q;
  logic [CNTW-1:0] last_q;
  logic [CNTW-1:0] last_d;
  logic            final_step;

  // Index of the last word: zero words means one, oversize counts clamp.
  always_comb begin
    last_d = '0;
    if (nwords == '0) begin
      last_d = '0;
    end else if (int'(nwords) > MAXWORDS) begin
      last_d = MAX_IDX;
    end else begin
      last_d = nwords - CNTW'(1);
    end
  end

  // The step that completes the last word of a running operation.
  always_comb begin
    final_step = (state_q == RUN) && step && (word_idx == last_q);
    ad_long    = busy && (word_idx != last_q);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= '0;
      word_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ad_carry_in   <= 1'b0;
      pi_save_flags <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= RUN;
            busy          <= 1'b1;
            word_idx      <= '0;
            last_q        <= last_d;
            pi_save_flags <= pc_plus1_inh & spec_xcry_ar0;
            ad_carry_in   <= xcry_cin(ar0, spec_xcry_ar0, cram_ad_carry, pc_plus1_inh);
          end
        end
        RUN: begin
          if (step) begin
            if (word_idx != last_q) begin
              word_idx    <= word_idx + CNTW'(1);
              ad_carry_in <= ad_cout;
            end else begin
              state_q <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  ctl_cry_flags u_cry_flags (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr_flags),
    .load    (final_step),
    .inhibit (pi_save_flags),
    .cout    (ad_cout),
    .cin_msb (ad_cin_msb),
    .cry0    (cry0),
    .cry1    (cry1),
    .ovf     (ovf)
  );

endmodule

// File: tb/tb_ctl_xcry_seq.sv
// Directed bench for ctl_xcry_seq: a table of whole operations with
// hand-computed carries and flags, plus hand-written multi-cycle sequences.
module tb_ctl_xcry_seq;

  localparam int MAXWORDS = 2;
  localparam int CNTW     = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [CNTW-1:0] nwords = '0;
  logic            cram_ad_carry = 1'b0;
  logic            spec_xcry_ar0 = 1'b0;
  logic            ar0 = 1'b0;
  logic            pc_plus1_inh = 1'b0;
  logic            step = 1'b0;
  logic            ad_cout = 1'b0;
  logic            ad_cin_msb = 1'b0;
  logic            clr_flags = 1'b0;
  logic            ad_carry_in;
  logic            ad_long;
  logic            busy;
  logic [CNTW-1:0] word_idx;
  logic            done;
  logic            pi_save_flags;
  logic            cry0;
  logic            cry1;
  logic            ovf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] nwords;
    logic       cram;
    logic       spec;
    logic       ar0;
    logic       inh;
    logic       cout0;     // carry-out on the first step of a 2-word op
    logic       cout_f;    // carry-out on the final step
    logic       cinmsb_f;  // carry into MSB on the final step
    logic       exp_cin0;
    logic       exp_cin1;
    logic       exp_pi;
    logic [1:0] exp_words;
    logic       exp_cry0;
    logic       exp_cry1;
  } vec_t;

  vec_t vecs[8];

  ctl_xcry_seq #(.MAXWORDS(MAXWORDS), .CNTW(CNTW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .nwords        (nwords),
    .cram_ad_carry (cram_ad_carry),
    .spec_xcry_ar0 (spec_xcry_ar0),
    .ar0           (ar0),
    .pc_plus1_inh  (pc_plus1_inh),
    .step          (step),
    .ad_cout       (ad_cout),
    .ad_cin_msb    (ad_cin_msb),
    .clr_flags     (clr_flags),
    .ad_carry_in   (ad_carry_in),
    .ad_long       (ad_long),
    .busy          (busy),
    .word_idx      (word_idx),
    .done          (done),
    .pi_save_flags (pi_save_flags),
    .cry0          (cry0),
    .cry1          (cry1),
    .ovf           (ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation from a table record; optional idle cycle before the first step.
  task automatic run_vec(input int idx, input vec_t v, input bit idle_gap);
    nwords        = v.nwords;
    cram_ad_carry = v.cram;
    spec_xcry_ar0 = v.spec;
    ar0           = v.ar0;
    pc_plus1_inh  = v.inh;
    start         = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d busy", idx), 8'(busy), 8'd1);
    chk($sformatf("v%0d idx0", idx), 8'(word_idx), 8'd0);
    chk($sformatf("v%0d pi", idx), 8'(pi_save_flags), 8'(v.exp_pi));
    chk($sformatf("v%0d cin0", idx), 8'(ad_carry_in), 8'(v.exp_cin0));
    chk($sformatf("v%0d long0", idx), 8'(ad_long), 8'(v.exp_words == 2'd2));
    if (v.exp_words == 2'd2) begin
      if (idle_gap) begin
        tick();
        chk($sformatf("v%0d hold cin", idx), 8'(ad_carry_in), 8'(v.exp_cin0));
        chk($sformatf("v%0d hold idx", idx), 8'(word_idx), 8'd0);
      end
      step       = 1'b1;
      ad_cout    = v.cout0;
      ad_cin_msb = 1'b0;
      tick();
      step = 1'b0;
      chk($sformatf("v%0d idx1", idx), 8'(word_idx), 8'd1);
      chk($sformatf("v%0d cin1", idx), 8'(ad_carry_in), 8'(v.exp_cin1));
      chk($sformatf("v%0d long1", idx), 8'(ad_long), 8'd0);
      chk($sformatf("v%0d done early", idx), 8'(done), 8'd0);
    end
    step       = 1'b1;
    ad_cout    = v.cout_f;
    ad_cin_msb = v.cinmsb_f;
    tick();
    step = 1'b0;
    chk($sformatf("v%0d done", idx), 8'(done), 8'd1);
    chk($sformatf("v%0d busy end", idx), 8'(busy), 8'd0);
    chk($sformatf("v%0d cry0", idx), 8'(cry0), 8'(v.exp_cry0));
    chk($sformatf("v%0d cry1", idx), 8'(cry1), 8'(v.exp_cry1));
    chk($sformatf("v%0d ovf", idx), 8'(ovf), 8'(v.exp_cry0 ^ v.exp_cry1));
    tick();
    chk($sformatf("v%0d done pulse", idx), 8'(done), 8'd0);
  endtask

  initial begin
    // nwords cram spec ar0 inh cout0 cout_f cinmsb_f | cin0 cin1 pi words cry0 cry1
    vecs[0] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1};
    vecs[2] = '{2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1};
    vecs[4] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[5] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1};
    vecs[6] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1};
    vecs[7] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst done", 8'(done), 8'd0);
    chk("rst idx", 8'(word_idx), 8'd0);
    chk("rst cin", 8'(ad_carry_in), 8'd0);
    chk("rst long", 8'(ad_long), 8'd0);
    chk("rst pi", 8'(pi_save_flags), 8'd0);
    chk("rst cry0", 8'(cry0), 8'd0);
    chk("rst cry1", 8'(cry1), 8'd0);
    chk("rst ovf", 8'(ovf), 8'd0);

    // Table of whole operations
    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i], (i % 2) == 1);
    end

    // Step while idle is ignored (flags are 0/1 from the last vector)
    step       = 1'b1;
    ad_cout    = 1'b1;
    ad_cin_msb = 1'b0;
    tick();
    step = 1'b0;
    chk("idle step busy", 8'(busy), 8'd0);
    chk("idle step done", 8'(done), 8'd0);
    chk("idle step cry0", 8'(cry0), 8'd0);
    chk("idle step cry1", 8'(cry1), 8'd1);

    // Start while busy is ignored
    nwords        = 2'd2;
    cram_ad_carry = 1'b1;
    spec_xcry_ar0 = 1'b0;
    ar0           = 1'b0;
    pc_plus1_inh  = 1'b0;
    start         = 1'b1;
    tick();
    nwords        = 2'd1;
    cram_ad_carry = 1'b0;
    spec_xcry_ar0 = 1'b1;
    pc_plus1_inh  = 1'b1;
    tick();
    start = 1'b0;
    chk("busy start idx", 8'(word_idx), 8'd0);
    chk("busy start cin", 8'(ad_carry_in), 8'd1);
    chk("busy start long", 8'(ad_long), 8'd1);
    chk("busy start pi", 8'(pi_save_flags), 8'd0);
    step    = 1'b1;
    ad_cout = 1'b0;
    tick();
    chk("busy start idx1", 8'(word_idx), 8'd1);
    chk("busy start cin1", 8'(ad_carry_in), 8'd0);

    // Final step together with clr_flags: the load wins
    ad_cout    = 1'b1;
    ad_cin_msb = 1'b0;
    clr_flags  = 1'b1;
    tick();
    step = 1'b0;
    chk("clr+load done", 8'(done), 8'd1);
    chk("clr+load cry0", 8'(cry0), 8'd1);
    chk("clr+load cry1", 8'(cry1), 8'd0);

    // clr alone clears; new start accepted in the done cycle
    nwords        = 2'd1;
    cram_ad_carry = 1'b0;
    spec_xcry_ar0 = 1'b0;
    pc_plus1_inh  = 1'b0;
    start         = 1'b1;
    tick();
    start     = 1'b0;
    clr_flags = 1'b0;
    chk("clr cry0", 8'(cry0), 8'd0);
    chk("clr cry1", 8'(cry1), 8'd0);
    chk("done-cycle start busy", 8'(busy), 8'd1);
    chk("done-cycle start cin", 8'(ad_carry_in), 8'd0);
    step       = 1'b1;
    ad_cout    = 1'b1;
    ad_cin_msb = 1'b1;
    tick();
    step = 1'b0;
    chk("done-cycle op done", 8'(done), 8'd1);
    chk("done-cycle op cry0", 8'(cry0), 8'd1);
    chk("done-cycle op cry1", 8'(cry1), 8'd1);
    tick();

    // Reset in the middle of a 2-word op
    nwords        = 2'd2;
    cram_ad_carry = 1'b1;
    start         = 1'b1;
    tick();
    start   = 1'b0;
    step    = 1'b1;
    ad_cout = 1'b1;
    tick();
    step = 1'b0;
    chk("pre-abort idx", 8'(word_idx), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 8'(busy), 8'd0);
    chk("abort done", 8'(done), 8'd0);
    chk("abort idx", 8'(word_idx), 8'd0);
    chk("abort cry0", 8'(cry0), 8'd0);
    chk("abort cry1", 8'(cry1), 8'd0);
    chk("abort long", 8'(ad_long), 8'd0);
    tick();
    chk("abort no done", 8'(done), 8'd0);

    // Normal operation after the abort
    run_vec(100, vecs[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
